// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave responder.
// Command codes, FSM states and field widths.
package spi_slave_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_e;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer with registered rise/fall detect.
// Level output is aligned with the edge pulses.
module spi_slave_sync #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] lvl_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] rise_q;
  logic [W-1:0] fall_q;

  // Resync pins, then compare against previous sample for edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave turning cmd/addr/data frames into
// single-cycle register bus reads and writes.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              spi_sclk,
  input  logic              spi_csn,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [31:0]       reg_rdata,
  output logic [1:0]        events_o
);

  localparam int RX_W = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic [2:0] lvl, rise, fall;

  spi_slave_sync #(
    .W(3)
  ) u_sync (
    .clk_i (HCLK),
    .rst_i (HRESET),
    .pin_i ({spi_sdi, spi_csn, spi_sclk}),
    .lvl_o (lvl),
    .rise_o(rise),
    .fall_o(fall)
  );

  logic sclk_rise, sclk_fall, csn_rise, csn_fall, sdi_bit;
  assign sclk_rise = rise[0];
  assign sclk_fall = fall[0];
  assign csn_rise  = rise[1];
  assign csn_fall  = fall[1];
  assign sdi_bit   = lvl[2];

  logic unused_sync;
  assign unused_sync = ^{lvl[1:0], rise[2], fall[2]};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RX_W-1:0]    rx_q, rx_d, rx_nxt;
  logic               is_rd_q, is_rd_d;
  logic [WORD_W-1:0]  tx_q, tx_d;
  logic [WORD_W-1:0]  pend_q, pend_d;
  logic               sdo_q, sdo_d;
  logic               oe_q, oe_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               re_q, re_d;
  logic               re_dly_q, re_dly_d;
  logic               to_tx_q, to_tx_d;
  logic [1:0]         ev_q, ev_d;

  assign rx_nxt = {rx_q[RX_W-2:0], sdi_bit};

  // State and datapath registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      is_rd_q  <= 1'b0;
      tx_q     <= '0;
      pend_q   <= '0;
      sdo_q    <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      re_dly_q <= 1'b0;
      to_tx_q  <= 1'b0;
      ev_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      is_rd_q  <= is_rd_d;
      tx_q     <= tx_d;
      pend_q   <= pend_d;
      sdo_q    <= sdo_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      re_dly_q <= re_dly_d;
      to_tx_q  <= to_tx_d;
      ev_q     <= ev_d;
    end
  end

  // Frame decode, shift registers, bus strobes and read streaming.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    is_rd_d  = is_rd_q;
    tx_d     = tx_q;
    pend_d   = pend_q;
    sdo_d    = sdo_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    re_dly_d = re_q;
    to_tx_d  = to_tx_q;
    ev_d     = '0;

    // Read data arrives one cycle after the strobe; the
    // first word feeds the shifter, prefetches the buffer.
    if (re_dly_q &&
        (state_q == ST_DUMMY || state_q == ST_RDATA)) begin
      if (to_tx_q) tx_d = reg_rdata;
      else         pend_d = reg_rdata;
    end

    if (we_q) addr_d = addr_q + ADDR_STEP;

    if (csn_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sdo_d   = 1'b0;
      oe_d    = 1'b0;
      ev_d[1] = (state_q != ST_IDLE);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (csn_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            rx_d    = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rx_d = rx_nxt;
            if (cnt_q == CMD_LAST) begin
              cnt_d   = '0;
              is_rd_d = (rx_nxt[7:0] == CMD_READ);
              state_d = cmd_known(rx_nxt[7:0]) ?
                        ST_ADDR : ST_IGNORE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            rx_d = rx_nxt;
            if (cnt_q == ADDR_LAST) begin
              cnt_d  = '0;
              addr_d = rx_nxt[ADDR_W-1:0];
              if (is_rd_q) begin
                re_d    = 1'b1;
                to_tx_d = 1'b1;
                state_d = ST_DUMMY;
              end else begin
                state_d = ST_WDATA;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_DUMMY: begin
          if (sclk_rise) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = '0;
              state_d = ST_RDATA;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            rx_d = rx_nxt;
            if (cnt_q == WORD_LAST) begin
              cnt_d   = '0;
              wdata_d = rx_nxt[WORD_W-1:0];
              we_d    = 1'b1;
              ev_d[0] = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_RDATA: begin
          if (sclk_fall) begin
            sdo_d = tx_q[WORD_W-1];
            tx_d  = {tx_q[WORD_W-2:0], 1'b0};
            oe_d  = 1'b1;
          end else if (sclk_rise) begin
            if (cnt_q == '0) begin
              addr_d  = addr_q + ADDR_STEP;
              re_d    = 1'b1;
              to_tx_d = 1'b0;
            end
            if (cnt_q == WORD_LAST) begin
              cnt_d = '0;
              tx_d  = pend_q;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_IGNORE: begin
          sdo_d = 1'b0;
          oe_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = oe_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign events_o   = ev_q;

endmodule
